// File: rtl/airport_security.sv
// rtl/airport_security.sv - security lane checkpoint: priority, passenger count, baggage parity, lane light FSM, scan token
// Optional COUNT_SATURATE_EN: passenger count saturates at 15 instead of wrapping.
module airport_security #(
   parameter int unsigned ALERT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] passenger_type,
   input  logic [3:0] sensor_pulse,
   input  logic [7:0] baggage_data,
   output logic [1:0] priority_code,
   output logic [3:0] count,
   output logic       parity,
   output logic [3:0] light,
   output logic [7:0] security_token
);

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_SCAN  = 4'b0010,
      ST_CLEAR = 4'b0100,
      ST_ALERT = 4'b1000
   } state_t;

   localparam logic [3:0] ALERT_LOAD = 4'(ALERT_CYCLES - 1);

   state_t     state;
   state_t     next_state;
   logic [3:0] alert_timer;
   logic [1:0] prio_next;
   logic       sensor_any;
   logic       scan_odd;

   assign sensor_any = |sensor_pulse;
   assign scan_odd   = ^baggage_data;
   assign light      = state;

   // VIP outranks staff, so the two upper classes swap codes
   always_comb begin
      prio_next = 2'b00;
      case (passenger_type)
         2'b00:   prio_next = 2'b00;
         2'b01:   prio_next = 2'b01;
         2'b10:   prio_next = 2'b11;
         default: prio_next = 2'b10;
      endcase
   end

   always_comb begin
      next_state = ST_IDLE;
      case (state)
         ST_IDLE:  next_state = sensor_any ? ST_SCAN : ST_IDLE;
         ST_SCAN:  next_state = scan_odd ? ST_ALERT : ST_CLEAR;
         ST_CLEAR: next_state = ST_IDLE;
         ST_ALERT: next_state = (alert_timer == 4'd0) ? ST_IDLE : ST_ALERT;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         priority_code  <= 2'b00;
         count          <= 4'd0;
         parity         <= 1'b0;
         security_token <= 8'h00;
         alert_timer    <= 4'd0;
      end else begin
         state         <= next_state;
         priority_code <= prio_next;
         parity        <= scan_odd;
`ifdef COUNT_SATURATE_EN
         if (sensor_any && count != 4'hF)
            count <= count + 4'd1;
`else
         if (sensor_any)
            count <= count + 4'd1;
`endif
         // token mixes in the registered count/priority seen during the scan cycle
         if (state == ST_SCAN) begin
            security_token <= baggage_data ^ {count, 2'b00, priority_code};
            if (scan_odd)
               alert_timer <= ALERT_LOAD;
         end
         if (state == ST_ALERT && alert_timer != 4'd0)
            alert_timer <= alert_timer - 4'd1;
      end
   end

endmodule

// File: tb/tb_airport_security.sv
// tb/tb_airport_security.sv - scoreboard bench for airport_security with directed vectors
module tb_airport_security;

   logic       clk;
   logic       reset;
   logic [1:0] passenger_type;
   logic [3:0] sensor_pulse;
   logic [7:0] baggage_data;
   logic [1:0] priority_code;
   logic [3:0] count;
   logic       parity;
   logic [3:0] light;
   logic [7:0] security_token;

   airport_security #(.ALERT_CYCLES(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .passenger_type (passenger_type),
      .sensor_pulse   (sensor_pulse),
      .baggage_data   (baggage_data),
      .priority_code  (priority_code),
      .count          (count),
      .parity         (parity),
      .light          (light),
      .security_token (security_token)
   );

   // mask bits: [4] priority, [3] count, [2] parity, [1] light, [0] token
   typedef struct {
      int         step;
      logic [4:0] mask;
      logic [1:0] pr;
      logic [3:0] cnt;
      logic       par;
      logic [3:0] lt;
      logic [7:0] tok;
   } exp_t;

   localparam logic [4:0] ALL = 5'b11111;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   step_no  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s step=%0d actual=%02h required=%02h", name, step, act, req);
      end
   endtask

   task automatic drive(input logic rst, input logic [1:0] pt, input logic [3:0] s, input logic [7:0] bag,
                        input logic [4:0] m, input logic [1:0] pr, input logic [3:0] cnt, input logic p,
                        input logic [3:0] lt, input logic [7:0] tk);
      exp_t e;
      @(negedge clk);
      reset          = rst;
      passenger_type = pt;
      sensor_pulse   = s;
      baggage_data   = bag;
      e.step = step_no;
      e.mask = m;
      e.pr   = pr;
      e.cnt  = cnt;
      e.par  = p;
      e.lt   = lt;
      e.tok  = tk;
      exp_q.push_back(e);
      step_no++;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.mask[4]) chk("priority", mon_e.step, {6'd0, priority_code}, {6'd0, mon_e.pr});
            if (mon_e.mask[3]) chk("count", mon_e.step, {4'd0, count}, {4'd0, mon_e.cnt});
            if (mon_e.mask[2]) chk("parity", mon_e.step, {7'd0, parity}, {7'd0, mon_e.par});
            if (mon_e.mask[1]) chk("light", mon_e.step, {4'd0, light}, {4'd0, mon_e.lt});
            if (mon_e.mask[0]) chk("token", mon_e.step, security_token, mon_e.tok);
         end
      end
   end

   initial begin
      logic [3:0] wc;
      reset          = 1'b1;
      passenger_type = 2'b00;
      sensor_pulse   = 4'h0;
      baggage_data   = 8'h00;

      // reset held with random inputs
      repeat (2)
         drive(1'b1, 2'($urandom), 4'($urandom), 8'($urandom), ALL, 2'b00, 4'd0, 1'b0, 4'b0001, 8'h00);

      // even-parity scans, VIP passenger
      drive(1'b0, 2'b10, 4'h1, 8'hAA, ALL, 2'b11, 4'd1, 1'b0, 4'b0010, 8'h00);
      drive(1'b0, 2'b10, 4'h1, 8'hAA, ALL, 2'b11, 4'd2, 1'b0, 4'b0100, 8'hB9);
      drive(1'b0, 2'b10, 4'h1, 8'hAA, ALL, 2'b11, 4'd3, 1'b0, 4'b0001, 8'hB9);
      drive(1'b0, 2'b10, 4'h1, 8'hAA, ALL, 2'b11, 4'd4, 1'b0, 4'b0010, 8'hB9);
      drive(1'b0, 2'b10, 4'h1, 8'hAA, ALL, 2'b11, 4'd5, 1'b0, 4'b0100, 8'hE9);
      drive(1'b0, 2'b10, 4'h0, 8'hAA, ALL, 2'b11, 4'd5, 1'b0, 4'b0001, 8'hE9);

      // odd-parity alert, sensor activity during ALERT only counts
      drive(1'b1, 2'b00, 4'h0, 8'h01, ALL, 2'b00, 4'd0, 1'b0, 4'b0001, 8'h00);
      drive(1'b0, 2'b00, 4'h2, 8'h01, ALL, 2'b00, 4'd1, 1'b1, 4'b0010, 8'h00);
      drive(1'b0, 2'b00, 4'h0, 8'h01, ALL, 2'b00, 4'd1, 1'b1, 4'b1000, 8'h11);
      drive(1'b0, 2'b00, 4'h0, 8'h01, ALL, 2'b00, 4'd1, 1'b1, 4'b1000, 8'h11);
      drive(1'b0, 2'b00, 4'h4, 8'h01, ALL, 2'b00, 4'd2, 1'b1, 4'b1000, 8'h11);
      drive(1'b0, 2'b00, 4'h0, 8'h01, ALL, 2'b00, 4'd2, 1'b1, 4'b1000, 8'h11);
      drive(1'b0, 2'b00, 4'h0, 8'h01, ALL, 2'b00, 4'd2, 1'b1, 4'b0001, 8'h11);
      drive(1'b0, 2'b00, 4'h0, 8'h01, ALL, 2'b00, 4'd2, 1'b1, 4'b0001, 8'h11);

      // priority mapping sweep while idle
      drive(1'b0, 2'b00, 4'h0, 8'h01, 5'b10010, 2'b00, 4'd0, 1'b0, 4'b0001, 8'h00);
      drive(1'b0, 2'b01, 4'h0, 8'h01, 5'b10010, 2'b01, 4'd0, 1'b0, 4'b0001, 8'h00);
      drive(1'b0, 2'b10, 4'h0, 8'h01, 5'b10010, 2'b11, 4'd0, 1'b0, 4'b0001, 8'h00);
      drive(1'b0, 2'b11, 4'h0, 8'h01, 5'b10010, 2'b10, 4'd0, 1'b0, 4'b0001, 8'h00);

      // counter wrap or saturate over 17 active clocks
      drive(1'b1, 2'b00, 4'h0, 8'h00, ALL, 2'b00, 4'd0, 1'b0, 4'b0001, 8'h00);
      for (int k = 1; k <= 17; k++) begin
`ifdef COUNT_SATURATE_EN
         wc = (k > 15) ? 4'd15 : 4'(k);
`else
         wc = 4'(k % 16);
`endif
         drive(1'b0, 2'b00, 4'hF, 8'h00, 5'b01000, 2'b00, wc, 1'b0, 4'b0001, 8'h00);
      end

      // reset in the middle of ALERT, then a fresh scan
      drive(1'b1, 2'b00, 4'h0, 8'h01, ALL, 2'b00, 4'd0, 1'b0, 4'b0001, 8'h00);
      drive(1'b0, 2'b00, 4'h1, 8'h01, ALL, 2'b00, 4'd1, 1'b1, 4'b0010, 8'h00);
      drive(1'b0, 2'b00, 4'h0, 8'h01, ALL, 2'b00, 4'd1, 1'b1, 4'b1000, 8'h11);
      drive(1'b0, 2'b00, 4'h0, 8'h01, ALL, 2'b00, 4'd1, 1'b1, 4'b1000, 8'h11);
      drive(1'b1, 2'b00, 4'h1, 8'h01, ALL, 2'b00, 4'd0, 1'b0, 4'b0001, 8'h00);
      drive(1'b0, 2'b01, 4'h1, 8'hAA, ALL, 2'b01, 4'd1, 1'b0, 4'b0010, 8'h00);
      drive(1'b0, 2'b01, 4'h0, 8'hAA, ALL, 2'b01, 4'd1, 1'b0, 4'b0100, 8'hBB);
      drive(1'b0, 2'b01, 4'h0, 8'hAA, ALL, 2'b01, 4'd1, 1'b0, 4'b0001, 8'hBB);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clk);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
